fetch_sequencer: RTL and testbench

- Program-counter sequencer and prefetch buffer in front of the InstructionMemory block.
- Drives the word address into instruction memory, captures the combinational read data into a small FIFO, and hands instructions to decode over a valid/ready handshake.
- Handles start, halt/drain and branch/jump redirect with FIFO flush.
- Sits between InstructionMemory and the decode stage of the simplified MIPS datapath.

---
 rtl/fetch_sequencer_if.sv | 37 +++
 rtl/fetch_sequencer.sv | 111 +++++++++++
 tb/tb_fetch_sequencer.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle for fetch_sequencer: control, instruction-memory and decode handshake.
// FETCH_PERF_CNT_EN adds the fetch_count/stall_count performance outputs.
interface fetch_sequencer_if;
  logic        start;
  logic        halt;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        busy;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
  logic [15:0] stall_count;

  modport master (
    input  start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_addr, inst_valid, inst, inst_pc, busy, fetch_count, stall_count
  );
  modport slave (
    output start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_addr, inst_valid, inst, inst_pc, busy, fetch_count, stall_count
  );
`else
  modport master (
    input  start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    output imem_addr, inst_valid, inst, inst_pc, busy
  );
  modport slave (
    output start, halt, redirect_valid, redirect_pc, imem_rdata, inst_ready,
    input  imem_addr, inst_valid, inst, inst_pc, busy
  );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer and prefetch FIFO between InstructionMemory and decode.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall counters.
module fetch_sequencer #(
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  fetch_sequencer_if.master bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_CNT  = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t         state, state_nx;
  logic [15:0]    pc;
  logic [AW-1:0]  rd_ptr, wr_ptr;
  logic [AW:0]    count;
  logic [15:0]    fifo_inst [FIFO_DEPTH];
  logic [15:0]    fifo_pc   [FIFO_DEPTH];
  logic           pop, push, flush, start_go;

  assign pop      = (count != '0) && bus.inst_ready;
  assign flush    = bus.redirect_valid;
  assign start_go = (state == IDLE) && !flush && bus.start && !bus.halt;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    if (flush) begin
      // Flushing empties the FIFO, so a drain in progress is already complete.
      if (state == DRAIN) state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (start_go) state_nx = FETCH;
        FETCH: begin
          push = (count < FULL_CNT) || pop;
          if (bus.halt) state_nx = DRAIN;
        end
        DRAIN: if ((count == '0) || ((count == ONE_CNT) && pop)) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= PC_RESET;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        pc     <= bus.redirect_pc;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 16'd1;
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + ONE_CNT;
          2'b01:   count <= count - ONE_CNT;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !flush && push) begin
      fifo_inst[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

  assign bus.imem_addr  = pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = (count != '0) ? fifo_inst[rd_ptr] : '0;
  assign bus.inst_pc    = (count != '0) ? fifo_pc[rd_ptr]   : '0;
  assign bus.busy       = (state == FETCH) || (state == DRAIN);

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt, stall_cnt;
  logic        stall;

  assign stall = (state == FETCH) && (count == FULL_CNT) && !pop;

  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (!flush && push && (fetch_cnt != '1)) fetch_cnt <= fetch_cnt + 16'd1;
      if (stall && (stall_cnt != '1))          stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign bus.fetch_count = fetch_cnt;
  assign bus.stall_count = stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random stimulus
// against a queue-based reference model of the prefetch behaviour.
module tb_fetch_sequencer;

  localparam int unsigned DEPTH = 2;
  localparam int M_IDLE  = 0;
  localparam int M_FETCH = 1;
  localparam int M_DRAIN = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(.PC_RESET(16'h0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 16'h2009;
      16'h0001: mem_word = 16'h200A;
      16'h0002: mem_word = 16'h012A;
      16'h0003: mem_word = 16'h012B;
      default:  mem_word = (a * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Reference model state
  logic [31:0] q [$];
  logic [15:0] m_pc;
  int          m_mode;
  logic [15:0] m_fetch, m_stall;

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic        ev;
    logic [15:0] ei, ep;
    ev = (q.size() > 0);
    ei = ev ? q[0][15:0]  : 16'h0000;
    ep = ev ? q[0][31:16] : 16'h0000;
    check_eq("inst_valid", {31'd0, bus.inst_valid}, {31'd0, ev});
    check_eq("inst",       {16'd0, bus.inst},       {16'd0, ei});
    check_eq("inst_pc",    {16'd0, bus.inst_pc},    {16'd0, ep});
    check_eq("imem_addr",  {16'd0, bus.imem_addr},  {16'd0, m_pc});
    check_eq("busy",       {31'd0, bus.busy},       {31'd0, (m_mode != M_IDLE)});
`ifdef FETCH_PERF_CNT_EN
    check_eq("fetch_count", {16'd0, bus.fetch_count}, {16'd0, m_fetch});
    check_eq("stall_count", {16'd0, bus.stall_count}, {16'd0, m_stall});
`endif
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic model_step(input logic rs, input logic st, input logic ht,
                            input logic rv, input logic [15:0] rp, input logic rdy);
    logic pop;
    logic full;
    pop  = (q.size() > 0) && rdy;
    full = (q.size() == DEPTH);
    if (rs) begin
      m_mode = M_IDLE; m_pc = 16'h0000; q.delete(); m_fetch = '0; m_stall = '0;
    end else begin
      if (m_mode == M_FETCH && full && !pop) m_stall = sat_inc(m_stall);
      if (rv) begin
        q.delete();
        m_pc = rp;
        if (m_mode == M_DRAIN) m_mode = M_IDLE;
      end else begin
        case (m_mode)
          M_IDLE: if (st && !ht) begin
            m_mode = M_FETCH; m_fetch = '0; m_stall = '0;
          end
          M_FETCH: begin
            if (pop) void'(q.pop_front());
            if (q.size() < DEPTH) begin
              q.push_back({m_pc, mem_word(m_pc)});
              m_pc    = m_pc + 16'd1;
              m_fetch = sat_inc(m_fetch);
            end
            if (ht) m_mode = M_DRAIN;
          end
          default: begin
            if (pop) void'(q.pop_front());
            if (q.size() == 0) m_mode = M_IDLE;
          end
        endcase
      end
    end
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare on the falling edge.
  task automatic cycle(input logic rs, input logic st, input logic ht,
                       input logic rv, input logic [15:0] rp, input logic rdy);
    reset              = rs;
    bus.start          = st;
    bus.halt           = ht;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.inst_ready     = rdy;
    model_step(rs, st, ht, rv, rp, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_cycles(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, rdy);
  endtask

  initial begin
    q.delete(); m_pc = 16'h0000; m_mode = M_IDLE; m_fetch = '0; m_stall = '0;

    // Reset and basic streaming from address 0
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("first_valid_lat", {31'd0, bus.inst_valid}, 32'd0);
    idle_cycles(1, 1'b1);
    check_eq("stream_inst0", {16'd0, bus.inst}, 32'h2009);
    idle_cycles(3, 1'b1);
    check_eq("stream_inst3", {16'd0, bus.inst}, 32'h012B);

    // Redirect to 1 while streaming
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b1);
    check_eq("redir_bubble", {31'd0, bus.inst_valid}, 32'd0);
    idle_cycles(1, 1'b1);
    check_eq("redir_pc1", {16'd0, bus.inst_pc}, 32'h0001);
    idle_cycles(2, 1'b1);

    // Back-pressure from a fresh start
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    idle_cycles(4, 1'b0);
    check_eq("bp_addr", {16'd0, bus.imem_addr}, 32'h0002);
    check_eq("bp_inst", {16'd0, bus.inst}, 32'h2009);
    idle_cycles(4, 1'b1);

    // Halt with a full FIFO, then drain
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    idle_cycles(3, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
    idle_cycles(2, 1'b0);
    check_eq("drain_busy", {31'd0, bus.busy}, 32'd1);
    idle_cycles(2, 1'b1);
    check_eq("drain_done_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("drain_pc", {16'd0, bus.imem_addr}, 32'h0002);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 1'b1);
    idle_cycles(1, 1'b1);

    // Wrap-around then reset mid-stream and restart
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b1);
    idle_cycles(1, 1'b1);
    check_eq("wrap_fffe", {16'd0, bus.inst_pc}, 32'hFFFE);
    idle_cycles(2, 1'b1);
    check_eq("wrap_0000", {16'd0, bus.inst_pc}, 32'h0000);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("rst_mid_addr", {16'd0, bus.imem_addr}, 32'h0000);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    idle_cycles(2, 1'b1);

`ifdef FETCH_PERF_CNT_EN
    // Three pushes, then four full-stall cycles; restart clears the counters
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    idle_cycles(2, 1'b1);
    idle_cycles(5, 1'b0);
    check_eq("perf_fetch3", {16'd0, bus.fetch_count}, 32'd3);
    check_eq("perf_stall4", {16'd0, bus.stall_count}, 32'd4);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
    idle_cycles(3, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    check_eq("perf_clear", {16'd0, bus.fetch_count}, 32'd0);
`endif

    // Random mix of all controls
    for (int i = 0; i < 600; i++) begin
      logic        rs, st, ht, rv, rdy;
      logic [15:0] rp;
      rs  = ($urandom_range(63) == 0);
      rv  = ($urandom_range(15) == 0);
      ht  = ($urandom_range(19) == 0);
      st  = ($urandom_range(5) == 0);
      rdy = ($urandom_range(9) < 7);
      rp  = ($urandom_range(3) == 0) ? 16'hFFFC + 16'($urandom_range(3)) : 16'($urandom);
      cycle(rs, st, ht, rv, rp, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
